// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer sequencer: state
// encoding, default geometry and address-width helpers.
package fc_pkg;

  // Sequencer state encoding. Plain constants keep the encoding fixed and
  // visible in waveforms and netlists.
  typedef logic [2:0] fc_state_t;

  localparam fc_state_t ST_LOAD  = 3'd0;
  localparam fc_state_t ST_CLEAR = 3'd1;
  localparam fc_state_t ST_MAC   = 3'd2;
  localparam fc_state_t ST_WAIT  = 3'd3;
  localparam fc_state_t ST_OUT   = 3'd4;

  // Default layer geometry and the matching address widths.
  localparam int FC_M_DEFAULT    = 6;
  localparam int FC_N_DEFAULT    = 6;
  localparam int FC_X_AW_DEFAULT = $clog2(FC_N_DEFAULT);
  localparam int FC_W_AW_DEFAULT = $clog2(FC_M_DEFAULT * FC_N_DEFAULT);

  // Counter width for a modulo-`range` counter; never narrower than one bit
  // so single-value counters (e.g. one lane) still elaborate.
  function automatic int fc_cnt_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/fc_delay_line.sv
// Resettable single-bit delay line. Output equals input delayed by DEPTH
// clock cycles; reset flushes every stage to zero.
module fc_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Shift the input in at the bottom; the top stage is the delayed output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages <= '0;
    end else begin
      // NOTE: non-blocking assignment so every flop samples its pre-edge value.
      stages <= DEPTH'({stages, d});
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/fc_seq_ctrl.sv
// Control sequencer for an M x N fully-connected layer computed P rows at a
// time. Loads the x vector, then per row group clears the accumulators,
// streams N columns of weights, waits out the read latency and hands the P
// lane results downstream one at a time.
// Optional build macro FC_SEQ_PERF_EN adds saturating busy/stall counters.
module fc_seq_ctrl
  import fc_pkg::*;
#(
  parameter int M       = FC_M_DEFAULT,
  parameter int N       = FC_N_DEFAULT,
  parameter int T       = 20,
  parameter int P       = 1,
  parameter int ACC_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      input_valid,
  output logic                      input_ready,
  input  logic                      output_ready,
  output logic                      output_valid,
  output logic [$clog2(N)-1:0]      addr_x,
  output logic                      wr_en_x,
  output logic [$clog2(M*N/P)-1:0]  addr_w,
  output logic                      clear_acc,
  output logic                      en_acc,
  output logic [P-1:0]              f_sel
`ifdef FC_SEQ_PERF_EN
  ,
  output logic [31:0]               perf_busy,
  output logic [31:0]               perf_stall
`endif
);

  localparam int GROUPS = M / P;
  localparam int XW     = $clog2(N);
  localparam int WW     = $clog2(M * N / P);
  localparam int PW     = fc_cnt_w(P);
  localparam int RW     = fc_cnt_w(GROUPS);
  localparam int LW     = fc_cnt_w(ACC_LAT);
  localparam logic [P-1:0] LANE0 = P'(1);

  // Parameter sanity checks at elaboration.
  if (M % P != 0) begin : g_bad_lanes
    $error("fc_seq_ctrl: M must be a multiple of P");
  end
  if (ACC_LAT < 1 || ACC_LAT > 4) begin : g_bad_lat
    $error("fc_seq_ctrl: ACC_LAT must be in 1..4");
  end
  if (N < 2) begin : g_bad_n
    $error("fc_seq_ctrl: N must be at least 2");
  end
  if (T < 1) begin : g_bad_t
    $error("fc_seq_ctrl: T must be positive");
  end

  fc_state_t      state;
  logic [XW-1:0]  load_cnt;
  logic [XW-1:0]  col_cnt;
  logic [WW-1:0]  w_base;
  logic [PW-1:0]  lane_cnt;
  logic [RW-1:0]  row_cnt;
  logic [LW-1:0]  wait_cnt;
  logic           mac_active;
  logic           accept;

  // Sequencer state and counters; w_base tracks row_group*N so the weight
  // address needs no multiplier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_LOAD;
      load_cnt <= '0;
      col_cnt  <= '0;
      w_base   <= '0;
      lane_cnt <= '0;
      row_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (load_cnt == XW'(N - 1)) begin
              load_cnt <= '0;
              state    <= ST_CLEAR;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          col_cnt <= '0;
          state   <= ST_MAC;
        end
        ST_MAC: begin
          if (col_cnt == XW'(N - 1)) begin
            col_cnt  <= '0;
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == LW'(ACC_LAT - 1)) begin
            wait_cnt <= '0;
            state    <= ST_OUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (output_ready) begin
            if (lane_cnt == PW'(P - 1)) begin
              lane_cnt <= '0;
              if (row_cnt == RW'(GROUPS - 1)) begin
                row_cnt <= '0;
                w_base  <= '0;
                state   <= ST_LOAD;
              end else begin
                row_cnt <= row_cnt + 1'b1;
                w_base  <= w_base + WW'(N);
                state   <= ST_CLEAR;
              end
            end else begin
              lane_cnt <= lane_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Output decode from state and counters; input_ready is held low while
  // reset is asserted even though the state already reads LOAD.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    input_ready  = reset && (state == ST_LOAD);
    accept       = input_valid && input_ready;
    wr_en_x      = accept;
    clear_acc    = (state == ST_CLEAR);
    mac_active   = (state == ST_MAC);
    output_valid = (state == ST_OUT);
    addr_x       = (state == ST_LOAD) ? load_cnt : col_cnt;
    addr_w       = w_base + WW'(col_cnt);
    f_sel        = LANE0 << lane_cnt;
  end

  // Accumulate enable trails the MAC phase by the memory read latency.
  fc_delay_line #(
    .DEPTH (ACC_LAT)
  ) u_acc_dly (
    .clk   (clk),
    .reset (reset),
    .d     (mac_active),
    .q     (en_acc)
  );

`ifdef FC_SEQ_PERF_EN
  // Saturating activity counters: cycles away from LOAD, and OUT cycles the
  // downstream consumer refused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (state != ST_LOAD && perf_busy != '1) begin
        perf_busy <= perf_busy + 1'b1;
      end
      if (state == ST_OUT && !output_ready && perf_stall != '1) begin
        perf_stall <= perf_stall + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed testbench for fc_seq_ctrl. Three instances share clock and
// handshake inputs; the ones not under test are held in reset.
//   a: M=6 N=6 P=1 ACC_LAT=1   b: P=3 ACC_LAT=1   c: P=1 ACC_LAT=3
module tb_fc_seq_ctrl;
  import fc_pkg::*;

  typedef struct packed {
    logic       ir;
    logic       wr;
    logic       clr;
    logic       en;
    logic       ov;
    logic [2:0] ax;
    logic [5:0] aw;
    logic [2:0] fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic iv, ordy;
  int   sel;
  int   n_total = 0;
  int   n_bad   = 0;

  logic                       ir_a, ov_a, wr_a, clr_a, en_a;
  logic [FC_X_AW_DEFAULT-1:0] ax_a;
  logic [FC_W_AW_DEFAULT-1:0] aw_a;
  logic [0:0]                 fs_a;
  logic                       ir_b, ov_b, wr_b, clr_b, en_b;
  logic [2:0]                 ax_b;
  logic [3:0]                 aw_b;
  logic [2:0]                 fs_b;
  logic                       ir_c, ov_c, wr_c, clr_c, en_c;
  logic [2:0]                 ax_c;
  logic [5:0]                 aw_c;
  logic [0:0]                 fs_c;
`ifdef FC_SEQ_PERF_EN
  logic [31:0] pb_a, ps_a, pb_b, ps_b, pb_c, ps_c;
`endif

  obs_t obs;

  always #5 clk = ~clk;

  fc_seq_ctrl #(.M(6), .N(6), .T(20), .P(1), .ACC_LAT(1)) dut_a (
    .clk(clk), .reset(rst_a), .input_valid(iv), .input_ready(ir_a),
    .output_ready(ordy), .output_valid(ov_a), .addr_x(ax_a), .wr_en_x(wr_a),
    .addr_w(aw_a), .clear_acc(clr_a), .en_acc(en_a), .f_sel(fs_a)
`ifdef FC_SEQ_PERF_EN
    , .perf_busy(pb_a), .perf_stall(ps_a)
`endif
  );

  fc_seq_ctrl #(.M(6), .N(6), .T(20), .P(3), .ACC_LAT(1)) dut_b (
    .clk(clk), .reset(rst_b), .input_valid(iv), .input_ready(ir_b),
    .output_ready(ordy), .output_valid(ov_b), .addr_x(ax_b), .wr_en_x(wr_b),
    .addr_w(aw_b), .clear_acc(clr_b), .en_acc(en_b), .f_sel(fs_b)
`ifdef FC_SEQ_PERF_EN
    , .perf_busy(pb_b), .perf_stall(ps_b)
`endif
  );

  fc_seq_ctrl #(.M(6), .N(6), .T(20), .P(1), .ACC_LAT(3)) dut_c (
    .clk(clk), .reset(rst_c), .input_valid(iv), .input_ready(ir_c),
    .output_ready(ordy), .output_valid(ov_c), .addr_x(ax_c), .wr_en_x(wr_c),
    .addr_w(aw_c), .clear_acc(clr_c), .en_acc(en_c), .f_sel(fs_c)
`ifdef FC_SEQ_PERF_EN
    , .perf_busy(pb_c), .perf_stall(ps_c)
`endif
  );

  // Route the instance under test onto one observation bundle.
  always_comb begin
    obs = '0;
    case (sel)
      0: begin
        obs.ir = ir_a; obs.wr = wr_a; obs.clr = clr_a; obs.en = en_a; obs.ov = ov_a;
        obs.ax = ax_a; obs.aw = aw_a; obs.fs = {2'b00, fs_a};
      end
      1: begin
        obs.ir = ir_b; obs.wr = wr_b; obs.clr = clr_b; obs.en = en_b; obs.ov = ov_b;
        obs.ax = ax_b; obs.aw = {2'b00, aw_b}; obs.fs = fs_b;
      end
      default: begin
        obs.ir = ir_c; obs.wr = wr_c; obs.clr = clr_c; obs.en = en_c; obs.ov = ov_c;
        obs.ax = ax_c; obs.aw = aw_c; obs.fs = {2'b00, fs_c};
      end
    endcase
  end

  // Hold everything in reset for one edge, then release only `which`
  // just after a rising edge; the following cycle is cycle 0.
  task automatic start(input int which);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    iv = 1'b0; ordy = 1'b0; sel = which;
    @(posedge clk); #1;
    case (which)
      0: rst_a = 1'b1;
      1: rst_b = 1'b1;
      default: rst_c = 1'b1;
    endcase
  endtask

  task automatic test_reset;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    iv = 1'b1; ordy = 1'b1; sel = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({obs.ir, obs.wr, obs.clr, obs.en, obs.ov} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_ctrl got=%b exp=00000", {obs.ir, obs.wr, obs.clr, obs.en, obs.ov});
    end
    n_total++;
    if (obs.ax !== 3'd0 || obs.aw !== 6'd0) begin
      n_bad++; $display("FAIL reset_addr got ax=%0d aw=%0d exp 0/0", obs.ax, obs.aw);
    end
    n_total++;
    if (obs.fs !== 3'b001) begin
      n_bad++; $display("FAIL reset_fsel got=%b exp=001", obs.fs);
    end
`ifdef FC_SEQ_PERF_EN
    n_total++;
    if (pb_a !== 32'd0 || ps_a !== 32'd0) begin
      n_bad++; $display("FAIL reset_perf got busy=%0d stall=%0d exp 0/0", pb_a, ps_a);
    end
`endif
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    n_total++;
    if (obs.ir !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready got=%b exp=1", obs.ir);
    end
  endtask

  // Full layer pass with input_valid and output_ready held high, checked
  // cycle by cycle against the hand-derived schedule: loads in cycles 0..5,
  // then per row group: CLEAR, N MAC cycles, ACC_LAT WAIT cycles, P OUT cycles.
  task automatic test_flow(input string name, input int which, input int p, input int lat);
    int period, groups, last, outs, k, g, o;
    logic e_ir, e_wr, e_clr, e_en, e_ov, chk_ax, chk_aw;
    logic [2:0] e_ax, e_fs;
    logic [5:0] e_aw;
    period = 1 + 6 + lat + p;
    groups = 6 / p;
    last   = 6 + groups * period;
    outs   = 0;
    start(which);
    iv = 1'b1; ordy = 1'b1;
    for (int c = 0; c <= last; c++) begin
      e_ir = 0; e_wr = 0; e_clr = 0; e_en = 0; e_ov = 0;
      chk_ax = 0; chk_aw = 0; e_ax = '0; e_aw = '0; e_fs = '0;
      if (c < 6) begin
        e_ir = 1; e_wr = 1; chk_ax = 1; e_ax = 3'(c);
      end else begin
        k = c - 6; g = k / period; o = k % period;
        if (g >= groups) begin
          e_ir = 1; e_wr = 1; chk_ax = 1; e_ax = 3'd0;
        end else begin
          if (o == 0) e_clr = 1;
          if (o >= 1 && o <= 6) begin
            chk_ax = 1; e_ax = 3'(o - 1);
            chk_aw = 1; e_aw = 6'(g * 6 + o - 1);
          end
          if (o >= 1 + lat && o <= 6 + lat) e_en = 1;
          if (o >= 7 + lat) begin
            e_ov = 1; e_fs = 3'(1 << (o - 7 - lat));
          end
        end
      end
      @(negedge clk);
      n_total++;
      if ({obs.ir, obs.wr, obs.clr, obs.en, obs.ov} !== {e_ir, e_wr, e_clr, e_en, e_ov}) begin
        n_bad++;
        $display("FAIL %s_ctrl cyc=%0d got ir,wr,clr,en,ov=%b exp=%b", name, c,
                 {obs.ir, obs.wr, obs.clr, obs.en, obs.ov}, {e_ir, e_wr, e_clr, e_en, e_ov});
      end
      if (chk_ax) begin
        n_total++;
        if (obs.ax !== e_ax) begin
          n_bad++; $display("FAIL %s_addr_x cyc=%0d got=%0d exp=%0d", name, c, obs.ax, e_ax);
        end
      end
      if (chk_aw) begin
        n_total++;
        if (obs.aw !== e_aw) begin
          n_bad++; $display("FAIL %s_addr_w cyc=%0d got=%0d exp=%0d", name, c, obs.aw, e_aw);
        end
      end
      if (e_ov) begin
        n_total++;
        if (obs.fs !== e_fs) begin
          n_bad++; $display("FAIL %s_f_sel cyc=%0d got=%b exp=%b", name, c, obs.fs, e_fs);
        end
      end
      if (obs.ov === 1'b1 && ordy) outs++;
      @(posedge clk); #1;
    end
    n_total++;
    if (outs != 6) begin
      n_bad++; $display("FAIL %s_result_count got=%0d exp=6", name, outs);
    end
  endtask

  // Downstream refuses the first result for five cycles (cycles 14..18).
  task automatic test_stall;
    start(0);
    iv = 1'b1; ordy = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 19) ordy = 1'b1;
      @(negedge clk);
      if (c >= 14 && c <= 18) begin
        n_total++;
        if ({obs.ov, obs.fs, obs.clr} !== {1'b1, 3'b001, 1'b0}) begin
          n_bad++; $display("FAIL stall_hold cyc=%0d got ov,fs,clr=%b exp=1_001_0", c, {obs.ov, obs.fs, obs.clr});
        end
      end
      if (c == 19) begin
        n_total++;
        if (obs.ov !== 1'b1) begin
          n_bad++; $display("FAIL stall_release cyc=%0d got ov=%b exp=1", c, obs.ov);
        end
      end
      if (c == 20) begin
        n_total++;
        if ({obs.clr, obs.ov} !== 2'b10) begin
          n_bad++; $display("FAIL stall_next_group cyc=%0d got clr,ov=%b exp=10", c, {obs.clr, obs.ov});
        end
`ifdef FC_SEQ_PERF_EN
        n_total++;
        if (ps_a !== 32'd5 || pb_a !== 32'd14) begin
          n_bad++; $display("FAIL stall_perf got stall=%0d busy=%0d exp 5/14", ps_a, pb_a);
        end
`endif
      end
      @(posedge clk); #1;
    end
  endtask

  // input_valid on even cycles only: six handshakes at cycles 0,2,..,10.
  task automatic test_toggle_valid;
    logic [2:0] e_ax;
    start(0);
    ordy = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      iv = (c % 2 == 0) && (c <= 10);
      @(negedge clk);
      if (c <= 10) begin
        e_ax = 3'((c + 1) / 2);
        n_total++;
        if (obs.wr !== iv || obs.ax !== e_ax || obs.ir !== 1'b1) begin
          n_bad++;
          $display("FAIL toggle_load cyc=%0d got wr=%b ax=%0d ir=%b exp wr=%b ax=%0d ir=1",
                   c, obs.wr, obs.ax, obs.ir, iv, e_ax);
        end
      end else begin
        n_total++;
        if ({obs.clr, obs.wr, obs.ir} !== 3'b100) begin
          n_bad++; $display("FAIL toggle_clear cyc=%0d got clr,wr,ir=%b exp=100", c, {obs.clr, obs.wr, obs.ir});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted mid-MAC (cycle 10, column 3) takes effect without a clock.
  task automatic test_reset_mid_mac;
    start(0);
    iv = 1'b1; ordy = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_total++;
    if (obs.ax !== 3'd3 || obs.en !== 1'b1) begin
      n_bad++; $display("FAIL midmac_pre got ax=%0d en=%b exp ax=3 en=1", obs.ax, obs.en);
    end
    #1 rst_a = 1'b0;
    #1;
    n_total++;
    if ({obs.ir, obs.wr, obs.clr, obs.en, obs.ov} !== 5'b00000 || obs.ax !== 3'd0 ||
        obs.aw !== 6'd0 || obs.fs !== 3'b001) begin
      n_bad++;
      $display("FAIL midmac_async got ctrl=%b ax=%0d aw=%0d fs=%b exp ctrl=00000 ax=0 aw=0 fs=001",
               {obs.ir, obs.wr, obs.clr, obs.en, obs.ov}, obs.ax, obs.aw, obs.fs);
    end
    @(posedge clk); #1;
    iv = 1'b0;
    rst_a = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_total++;
      if ({obs.ir, obs.wr, obs.clr, obs.en, obs.ov} !== 5'b10000 || obs.ax !== 3'd0) begin
        n_bad++;
        $display("FAIL midmac_after cyc=%0d got ir,wr,clr,en,ov=%b ax=%0d exp=10000 ax=0",
                 c, {obs.ir, obs.wr, obs.clr, obs.en, obs.ov}, obs.ax);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    iv = 1'b0; ordy = 1'b0; sel = 0;
    test_reset;
    test_flow("basic", 0, 1, 1);
    test_flow("lanes", 1, 3, 1);
    test_flow("acclat", 2, 1, 3);
    test_stall;
    test_toggle_valid;
    test_reset_mid_mac;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
